memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, byte-address width; memory holds 2**ADDR_W bytes.
REQ-002 SHALL have parameter LATENCY, default 2, number of wait cycles from request capture to MFC; legal range 1..15.
REQ-003 SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port RAM_enable  input  1  request strobe from the datapath; it is held high until MFC is seen.
REQ-006 SHALL have port RAM_OpCode  input  6  SPARC op3 of the access.
REQ-007 SHALL have port Address  input  ADDR_W  byte address, taken from MAR.
REQ-008 SHALL have port DataIn  input  32  store data, taken from MDR.
REQ-009 SHALL have port DataOut  output  32  load data, destined for MDR.
REQ-010 SHALL have port MFC  output  1  memory function complete.
REQ-011 SHALL have port Misaligned  output  1  alignment fault flag, valid while MFC is high.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, WAIT and DONE.
REQ-013 IDLE: when RAM_enable=1, SHALL capture OpCode, Address and DataIn, load the counter with LATENCY-1, and go to WAIT.
REQ-014 WAIT: SHALL decrement the counter each cycle; at count 0 SHALL perform the access and go to DONE.
REQ-015 DONE: SHALL drive MFC=1 and hold DataOut and Misaligned stable until RAM_enable=0, then return to IDLE with MFC=0 on the next edge.
REQ-016 Latency SHALL be fixed: MFC rises exactly LATENCY+1 edges after the edge on which IDLE saw RAM_enable=1.
REQ-017 Input changes after capture SHALL be ignored; only captured values are used.
REQ-018 Supported opcodes SHALL be: LD 000000, LDUB 000001, LDUH 000010, LDSB 001001, LDSH 001010, ST 000100, STB 000101, STH 000110.
REQ-019 Memory SHALL be big-endian: the byte at Address is the most significant byte of a halfword or word.
REQ-020 LDUB and LDUH SHALL zero-extend to 32 bits; LDSB and LDSH SHALL sign-extend from bit 7 and bit 15 respectively.
REQ-021 STB SHALL write DataIn[7:0]; STH SHALL write DataIn[15:0]; ST SHALL write all 32 bits; all other bytes SHALL be unchanged.
REQ-022 A halfword access with Address[0]=1, or a word access with Address[1:0]!=0, SHALL set Misaligned=1, SHALL perform no write, and SHALL drive DataOut=0.
REQ-023 An unsupported opcode SHALL complete the handshake with MFC, set Misaligned=0, perform no write, and leave DataOut unchanged.
REQ-024 A word or halfword access SHALL address bytes within the array with no wrap-around; an aligned address guarantees this.
REQ-025 A store SHALL leave DataOut holding its previous value.
REQ-026 The block SHALL accept a new request no earlier than one cycle after returning to IDLE; there is no back-to-back pipelining.
REQ-027 If RAM_enable falls during WAIT, the access SHALL still complete and MFC SHALL assert for exactly one cycle in DONE before the FSM returns to IDLE.

Reset
REQ-028 RESET=0 SHALL asynchronously force state=IDLE, counter=0, MFC=0, Misaligned=0 and DataOut=0.
REQ-029 Memory array contents SHALL NOT be cleared by reset; a store in flight when reset asserts SHALL be discarded (no partial write).
REQ-030 After RESET returns to 1, the first request SHALL be accepted on the first rising edge with RAM_enable=1.

Verification
REQ-031 ST 0xDEADBEEF to address 0x010, then LD from 0x010: DataOut=0xDEADBEEF; MFC rises 3 edges after capture with LATENCY=2.
REQ-032 After REQ-031: LDUB 0x011 -> 0x000000AD; LDSB 0x010 -> 0xFFFFFFDE; LDSH 0x012 -> 0xFFFFBEEF; LDUH 0x012 -> 0x0000BEEF.
REQ-033 STB 0x55 to address 0x013, then LD 0x010 -> 0xDEADBE55; STH 0x1234 to 0x010, then LD 0x010 -> 0x1234BE55.
REQ-034 LD from 0x011 -> Misaligned=1 and DataOut=0; ST to 0x012 -> Misaligned=1 and memory unchanged when verified by a subsequent LD 0x010.
REQ-035 Hold RAM_enable high for 5 cycles after MFC -> MFC stays 1 and DataOut stays stable; drop RAM_enable -> MFC=0 on the next edge.
REQ-036 Assert RESET=0 mid-WAIT during an ST to 0x020 -> MFC=0 immediately; a subsequent LD 0x020 returns the pre-store value.

Source files
------------

// File: rtl/memory_responder.sv
// Byte-addressed big-endian memory slave for a SPARC-style datapath.
// Each request is captured, serviced after a fixed wait, then acknowledged with MFC.
`default_nettype none

module memory_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              RAM_enable,
  input  logic [5:0]        RAM_OpCode,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              Misaligned
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [7:0]        mem [DEPTH];

  logic              is_word, is_half, is_store, is_load, misalign, fire;
  logic [ADDR_W-1:0] w0, w1, w2, w3, h0, h1;
  logic [7:0]        byte_b, half_hi, half_lo;
  logic [31:0]       load_data;

  // Decode and read path operate only on the captured request.
  always_comb begin
    is_word  = 1'b0;
    is_half  = 1'b0;
    is_store = 1'b0;
    is_load  = 1'b0;
    case (op_q)
      OP_LD:            begin is_word = 1'b1; is_load  = 1'b1; end
      OP_LDUH, OP_LDSH: begin is_half = 1'b1; is_load  = 1'b1; end
      OP_LDUB, OP_LDSB: begin                 is_load  = 1'b1; end
      OP_ST:            begin is_word = 1'b1; is_store = 1'b1; end
      OP_STH:           begin is_half = 1'b1; is_store = 1'b1; end
      OP_STB:           begin                 is_store = 1'b1; end
      default:          ;
    endcase
    misalign = (is_half & addr_q[0]) | (is_word & (addr_q[1:0] != 2'b00));

    w0 = {addr_q[ADDR_W-1:2], 2'b00};
    w1 = {addr_q[ADDR_W-1:2], 2'b01};
    w2 = {addr_q[ADDR_W-1:2], 2'b10};
    w3 = {addr_q[ADDR_W-1:2], 2'b11};
    h0 = {addr_q[ADDR_W-1:1], 1'b0};
    h1 = {addr_q[ADDR_W-1:1], 1'b1};

    byte_b  = mem[addr_q];
    half_hi = mem[h0];
    half_lo = mem[h1];

    load_data = 32'h0;
    case (op_q)
      OP_LD:   load_data = {mem[w0], mem[w1], mem[w2], mem[w3]};
      OP_LDUB: load_data = {24'h0, byte_b};
      OP_LDSB: load_data = {{24{byte_b[7]}}, byte_b};
      OP_LDUH: load_data = {16'h0, half_hi, half_lo};
      OP_LDSH: load_data = {{16{half_hi[7]}}, half_hi, half_lo};
      default: load_data = 32'h0;
    endcase
  end

  assign fire = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (RAM_enable) state_nx = WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = DONE;
      DONE:    if (MFC && !RAM_enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_q       <= 6'd0;
      addr_q     <= '0;
      din_q      <= 32'h0;
      MFC        <= 1'b0;
      Misaligned <= 1'b0;
      DataOut    <= 32'h0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          MFC <= 1'b0;
          if (RAM_enable) begin
            op_q   <= RAM_OpCode;
            addr_q <= Address;
            din_q  <= DataIn;
            cnt    <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            Misaligned <= misalign;
            if (misalign)     DataOut <= 32'h0;
            else if (is_load) DataOut <= load_data;
          end
        end
        // MFC is raised one edge after entering DONE so the total latency is LATENCY+1.
        DONE:    MFC <= !(MFC && !RAM_enable);
        default: MFC <= 1'b0;
      endcase
    end
  end

  // No reset on the array: contents survive reset, and a reset before fire drops the store.
  always_ff @(posedge Clk) begin
    if (fire && is_store && !misalign) begin
      case (op_q)
        OP_ST: begin
          mem[w0] <= din_q[31:24];
          mem[w1] <= din_q[23:16];
          mem[w2] <= din_q[15:8];
          mem[w3] <= din_q[7:0];
        end
        OP_STH: begin
          mem[h0] <= din_q[15:8];
          mem[h1] <= din_q[7:0];
        end
        OP_STB:  mem[addr_q] <= din_q[7:0];
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: randomized and directed accesses checked against a byte-array model.
`default_nettype none

module tb_memory_responder;

  localparam int ADDR_W  = 9;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 1 << ADDR_W;

  logic        Clk = 1'b0;
  logic        RESET = 1'b0;
  logic        RAM_enable = 1'b0;
  logic [5:0]  RAM_OpCode = 6'd0;
  logic [8:0]  Address = 9'd0;
  logic [31:0] DataIn = 32'd0;
  logic [31:0] DataOut;
  logic        MFC;
  logic        Misaligned;

  memory_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .Clk(Clk), .RESET(RESET), .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .Misaligned(Misaligned)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    logic [31:0] dout;
    logic        mis;
    int          cap;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mm [DEPTH];
  logic [31:0] m_dout = 32'h0;
  logic [5:0]  ops [8] = '{6'b000000, 6'b000001, 6'b000010, 6'b001001,
                           6'b001010, 6'b000100, 6'b000101, 6'b000110};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: size/sign/store rules applied directly to a byte array.
  task automatic model(input logic [5:0] op, input logic [8:0] a, input logic [31:0] d,
                       output logic [31:0] dout, output logic mis);
    int     size;
    bit     store, sgn, known;
    longint v;
    size = 1; store = 0; sgn = 0; known = 1; v = 0;
    case (op)
      6'b000000: size = 4;
      6'b000001: size = 1;
      6'b000010: size = 2;
      6'b001001: begin size = 1; sgn = 1; end
      6'b001010: begin size = 2; sgn = 1; end
      6'b000100: begin size = 4; store = 1; end
      6'b000101: begin size = 1; store = 1; end
      6'b000110: begin size = 2; store = 1; end
      default:   known = 0;
    endcase
    mis = known && ((int'(a) % size) != 0);
    if (!known) dout = m_dout;
    else if (mis) dout = 32'h0;
    else if (store) begin
      for (int i = 0; i < size; i++) mm[int'(a) + i] = 8'(d >> (8 * (size - 1 - i)));
      dout = m_dout;
    end else begin
      for (int i = 0; i < size; i++) v = v * 256 + longint'(mm[int'(a) + i]);
      if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      dout = v[31:0];
    end
    m_dout = dout;
  endtask

  // Monitor: pops on each MFC rising, then checks the response stays stable while MFC holds.
  logic        mfc_prev = 1'b0;
  logic [31:0] held_d = 32'h0;
  logic        held_m = 1'b0;
  exp_t        mon_e;
  always @(negedge Clk) begin
    if (!RESET) mfc_prev = 1'b0;
    else begin
      if (MFC && !mfc_prev) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_mfc: got MFC=1 expected no pending request");
        end else begin
          mon_e = sb.pop_front();
          check("dataout", DataOut, mon_e.dout);
          check("misaligned", {31'd0, Misaligned}, {31'd0, mon_e.mis});
          check("latency", cyc - mon_e.cap, LATENCY + 1);
          held_d = mon_e.dout;
          held_m = mon_e.mis;
        end
      end else if (MFC && mfc_prev) begin
        check("dout_stable", DataOut, held_d);
        check("mis_stable", {31'd0, Misaligned}, {31'd0, held_m});
      end
      mfc_prev = MFC;
    end
  end

  task automatic req(input logic [5:0] op, input logic [8:0] a, input logic [31:0] d,
                     input int hold, input bit early);
    exp_t        e;
    logic [31:0] ed;
    logic        em;
    int          waited;
    @(negedge Clk);
    RAM_enable = 1'b1; RAM_OpCode = op; Address = a; DataIn = d;
    model(op, a, d, ed, em);
    e.dout = ed; e.mis = em; e.cap = cyc + 1;
    sb.push_back(e);
    @(negedge Clk);
    // Captured values must be the only ones used from here on.
    RAM_OpCode = 6'($urandom); Address = 9'($urandom); DataIn = $urandom;
    if (early) RAM_enable = 1'b0;
    waited = 0;
    while (MFC !== 1'b1 && waited < 40) begin
      @(negedge Clk);
      waited++;
    end
    if (MFC !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL mfc_timeout: got MFC=%b expected 1 within 40 cycles", MFC);
      RAM_enable = 1'b0;
      return;
    end
    if (early) begin
      @(negedge Clk);
      check("mfc_one_cycle", {31'd0, MFC}, 32'd0);
    end else begin
      repeat (hold) @(negedge Clk);
      RAM_enable = 1'b0;
      @(posedge Clk);
      #1 check("mfc_drop", {31'd0, MFC}, 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [8:0]  a;
    logic [5:0]  op;
    logic [31:0] pre20;
    repeat (3) @(negedge Clk);
    check("reset_mfc", {31'd0, MFC}, 32'd0);
    check("reset_mis", {31'd0, Misaligned}, 32'd0);
    check("reset_dout", DataOut, 32'd0);
    RESET = 1'b1;

    for (int i = 0; i < DEPTH / 4; i++) req(6'b000100, 9'(i * 4), $urandom, 0, 0);

    req(6'b000100, 9'h010, 32'hDEADBEEF, 0, 0);
    req(6'b000000, 9'h010, 32'h0, 0, 0);
    check("ld_deadbeef", DataOut, 32'hDEADBEEF);
    req(6'b000001, 9'h011, 32'h0, 0, 0);
    check("ldub_011", DataOut, 32'h000000AD);
    req(6'b001001, 9'h010, 32'h0, 0, 0);
    check("ldsb_010", DataOut, 32'hFFFFFFDE);
    req(6'b001010, 9'h012, 32'h0, 0, 0);
    check("ldsh_012", DataOut, 32'hFFFFBEEF);
    req(6'b000010, 9'h012, 32'h0, 0, 0);
    check("lduh_012", DataOut, 32'h0000BEEF);
    req(6'b000101, 9'h013, 32'hAAAAAA55, 0, 0);
    check("st_keeps_dout", DataOut, 32'h0000BEEF);
    req(6'b000000, 9'h010, 32'h0, 0, 0);
    check("ld_after_stb", DataOut, 32'hDEADBE55);
    req(6'b000110, 9'h010, 32'hFFFF1234, 0, 0);
    req(6'b000000, 9'h010, 32'h0, 0, 0);
    check("ld_after_sth", DataOut, 32'h1234BE55);
    req(6'b000000, 9'h011, 32'h0, 0, 0);
    check("ld_misaligned_dout", DataOut, 32'h0);
    check("ld_misaligned_flag", {31'd0, Misaligned}, 32'd1);
    req(6'b000100, 9'h012, 32'h01020304, 0, 0);
    req(6'b000000, 9'h010, 32'h0, 5, 0);
    check("st_misaligned_nowrite", DataOut, 32'h1234BE55);
    req(6'b111111, 9'h010, 32'h0, 0, 0);
    check("unsupported_keeps", DataOut, 32'h1234BE55);
    req(6'b000000, 9'h010, 32'h0, 0, 1);

    // Reset in the middle of a store's wait phase.
    pre20 = {mm[32], mm[33], mm[34], mm[35]};
    @(negedge Clk);
    RAM_enable = 1'b1; RAM_OpCode = 6'b000100; Address = 9'h020; DataIn = ~pre20;
    @(negedge Clk);
    RESET = 1'b0;
    #1 check("rst_mfc", {31'd0, MFC}, 32'd0);
    check("rst_dout", DataOut, 32'd0);
    check("rst_mis", {31'd0, Misaligned}, 32'd0);
    RAM_enable = 1'b0;
    m_dout = 32'h0;
    repeat (2) @(negedge Clk);
    RESET = 1'b1;
    req(6'b000000, 9'h020, 32'h0, 0, 0);
    check("ld_after_reset", DataOut, pre20);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 8) == 8) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      a  = 9'($urandom);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      req(op, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end

    repeat (5) @(negedge Clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
